nibble_serial_addsub_ctrl: RTL and testbench

//   Sequences a single 4-bit ripple add/sub slice over WIDTH/4 clock cycles to add or subtract

---
 rtl/nibble_serial_addsub_ctrl.sv | 164 ++++++++++++++++
 tb/tb_nibble_serial_addsub_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_addsub_ctrl
//  Description : Nibble-serial two's-complement adder/subtractor. One 4-bit
//                ripple slice is reused over WIDTH/4 cycles, LS nibble first,
//                with a registered inter-nibble carry. The operand side and
//                the result side each use a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIB - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_zero;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_lo3;
    logic [4:0]       w_full;
    logic             w_c3;
    logic             w_c4;
    logic             w_last;
    logic [WIDTH-1:0] w_result_nxt;

    // Single 4-bit slice: selected nibble of A plus (optionally inverted) nibble of B plus carry
    always_comb begin
        w_a_nib      = r_a[4*r_idx +: 4];
        w_b_nib      = r_b[4*r_idx +: 4] ^ {4{r_sub}};
        w_lo3        = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + {3'b000, r_carry};
        w_full       = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};
        w_c3         = w_lo3[3];
        w_c4         = w_full[4];
        w_last       = (r_idx == c_LAST_IDX);
        w_result_nxt = r_result;
        w_result_nxt[4*r_idx +: 4] = w_full[3:0];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs; in_ready stays low while reset is held
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, per-nibble result write and final flag update; abort freezes the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_sub   <= op_sub;
                        r_idx   <= '0;
                        // Subtraction is A + ~B + 1: the +1 enters as the initial carry
                        r_carry <= op_sub;
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        r_result <= w_result_nxt;
                        r_carry  <= w_c4;
                        r_idx    <= r_idx + c_IDX_ONE;
                        if (w_last) begin
                            r_carry_out <= w_c4;
                            r_overflow  <= w_c3 ^ w_c4;
                            r_zero      <= (w_result_nxt == '0);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_addsub_ctrl
//  Description : Self-checking bench for nibble_serial_addsub_ctrl. A
//                transaction-level model predicts every output each cycle;
//                directed operations pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] op_a      = '0;
    logic [WIDTH-1:0] op_b      = '0;
    logic             op_sub    = 1'b0;
    logic             abort     = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             busy;

    always #5 clk = ~clk;

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word arithmetic reference: result, carry (no borrow) and signed overflow
    function automatic void model_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic s, output logic [WIDTH-1:0] r,
                                     output logic co, output logic ov);
        longint ua, ub, sa, sb, sr, lim;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = longint'(1) << (WIDTH - 1);
        if (s) begin
            r  = a - b;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = a + b;
            co = ((ua + ub) >= (longint'(1) << WIDTH));
            sr = sa + sb;
        end
        ov = (sr >= lim) || (sr < -lim);
    endfunction

    // Transaction model: phase 0 idle, 1 computing, 2 result pending
    int               m_phase = 0;
    int               m_cnt   = 0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_c     = 1'b0;
    logic             m_v     = 1'b0;
    logic [WIDTH-1:0] m_res   = '0;
    logic             m_co    = 1'b0;
    logic             m_ov    = 1'b0;
    logic             m_z     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cnt   = 0;
            m_res   = '0;
            m_co    = 1'b0;
            m_ov    = 1'b0;
            m_z     = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    model_op(op_a, op_b, op_sub, m_sum, m_c, m_v);
                    m_phase = 1;
                    m_cnt   = 0;
                end
                1: if (abort) begin
                    m_phase = 0;
                end else begin
                    // Nibbles of the whole-word sum appear one per cycle, LS first
                    m_res[4*m_cnt +: 4] = m_sum[4*m_cnt +: 4];
                    if (m_cnt == NIB - 1) begin
                        m_co    = m_c;
                        m_ov    = m_v;
                        m_z     = (m_sum == '0);
                        m_phase = 2;
                    end
                    m_cnt++;
                end
                default: if (abort || out_ready) m_phase = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 32'(out_valid), 32'(m_phase == 2));
            check("in_ready",  32'(in_ready),  32'(m_phase == 0));
            check("busy",      32'(busy),      32'(m_phase != 0));
            check("result",    32'(result),    32'(m_res));
            check("carry_out", 32'(carry_out), 32'(m_co));
            check("overflow",  32'(overflow),  32'(m_ov));
            check("zero",      32'(zero),      32'(m_z));
        end
    end

    // Directed operation with literal expectations, optional DONE backpressure
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [WIDTH-1:0] er, input logic eco,
                          input logic eov, input logic ez, input int hold);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; op_sub = s; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; op_sub = ~s;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check({tag, "_latency"},  32'(lat),       32'(NIB));
        check({tag, "_result"},   32'(result),    32'(er));
        check({tag, "_carry"},    32'(carry_out), 32'(eco));
        check({tag, "_overflow"}, 32'(overflow),  32'(eov));
        check({tag, "_zero"},     32'(zero),      32'(ez));
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1'b1;
            op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
            check({tag, "_bp_result"},   32'(result),    32'(er));
            check({tag, "_bp_in_ready"}, 32'(in_ready),  32'(0));
            check({tag, "_bp_valid"},    32'(out_valid), 32'(1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_hs_busy"},  32'(busy),      32'(0));
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_result",    32'(result),    32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'(1));

        run_op("t1",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);
        run_op("t2a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        run_op("t2b", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("t3a", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        run_op("t3b", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
        run_op("t4",  16'hA5A5, 16'h1111, 1'b0, 16'hB6B6, 1'b0, 1'b0, 1'b0, 3);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        op_a = 16'h1357; op_b = 16'h2468; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_busy_before", 32'(busy), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_result",   32'(result),    32'(0));
        check("t5_valid",    32'(out_valid), 32'(0));
        check("t5_busy",     32'(busy),      32'(0));
        check("t5_in_ready", 32'(in_ready),  32'(0));
        check("t5_flags",    32'({carry_out, overflow, zero}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t5", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);

        // Abort while the second nibble is being computed
        @(negedge clk);
        op_a = 16'h4444; op_b = 16'h1111; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy", 32'(busy), 32'(0));
        @(negedge clk);
        abort = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("t6_no_valid", 32'(out_valid), 32'(0));
        end
        run_op("t6", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       op_a = 16'h7FFF;
                1:       op_a = 16'h8000;
                2:       op_a = 16'hFFFF;
                default: op_a = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       op_b = 16'h0001;
                1:       op_b = op_a;
                2:       op_b = 16'h0000;
                default: op_b = WIDTH'($urandom);
            endcase
            op_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            abort     = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
